vga_fill_master: RTL

VGA_FILL_MASTER -- requirements
Module: vga_fill_master

---
 rtl/vga_fill_master_if.sv | 10 +
 rtl/vga_fill_master.sv | 114 +++++++++++
 2 files changed

// File: rtl/vga_fill_master_if.sv
// Avalon-MM master bus used by vga_fill_master to plot pixels into a VGA slave.
interface vga_fill_master_if;
  logic [3:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  modport master (output m_address, m_write, m_writedata, input m_waitrequest);
  modport slave  (input m_address, m_write, m_writedata, output m_waitrequest);
endinterface

// File: rtl/vga_fill_master.sv
// Rectangle fill engine: streams one Avalon-MM pixel write per accepted cycle in raster order.
// Define VGA_FILL_CLIP_EN to clip the rectangle to the MAX_X x MAX_Y visible area.
module vga_fill_master #(
  parameter int MAX_X = 160,
  parameter int MAX_Y = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        x0,
  input  logic [7:0]        x1,
  input  logic [6:0]        y0,
  input  logic [6:0]        y1,
  input  logic [2:0]        colour,
  output logic              busy,
  output logic              done,
  vga_fill_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

`ifdef VGA_FILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [8:0] X_LIMIT = 9'(MAX_X - 1);
  localparam logic [8:0] Y_LIMIT = 9'(MAX_Y - 1);

  state_t     state, state_next;
  logic [8:0] x_min, x_max, y_min, y_max;
  logic [8:0] x_cur, y_cur;
  logic [2:0] fill_colour;

  logic [8:0] n_x_min, n_x_max, n_y_min, n_y_max;
  logic [8:0] c_x_max, c_y_max;
  logic       off_screen;
  logic       last_pixel;
  logic       accept;

  // Counters are 9 bits wide so stepping past x=255 never wraps back into range.
  always_comb begin
    n_x_min    = (x0 < x1) ? {1'b0, x0} : {1'b0, x1};
    n_x_max    = (x0 < x1) ? {1'b0, x1} : {1'b0, x0};
    n_y_min    = (y0 < y1) ? {2'b00, y0} : {2'b00, y1};
    n_y_max    = (y0 < y1) ? {2'b00, y1} : {2'b00, y0};
    c_x_max    = (CLIP_EN && (n_x_max > X_LIMIT)) ? X_LIMIT : n_x_max;
    c_y_max    = (CLIP_EN && (n_y_max > Y_LIMIT)) ? Y_LIMIT : n_y_max;
    off_screen = CLIP_EN && ((n_x_min > X_LIMIT) || (n_y_min > Y_LIMIT));
  end

  assign last_pixel = (x_cur == x_max) && (y_cur == y_max);
  assign accept     = (state == WRITE) && !bus.m_waitrequest;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    busy            = 1'b0;
    done            = 1'b0;
    bus.m_write     = 1'b0;
    bus.m_address   = 4'd0;
    bus.m_writedata = 32'd0;
    case (state)
      IDLE: begin
        if (start) state_next = off_screen ? DONE : WRITE;
      end
      WRITE: begin
        busy            = 1'b1;
        bus.m_write     = 1'b1;
        bus.m_writedata = {13'd0, fill_colour, x_cur[7:0], 1'b0, y_cur[6:0]};
        if (accept && last_pixel) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture only in IDLE so later input changes cannot disturb a running fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_min       <= '0;
      x_max       <= '0;
      y_min       <= '0;
      y_max       <= '0;
      x_cur       <= '0;
      y_cur       <= '0;
      fill_colour <= '0;
    end else if (state == IDLE && start) begin
      x_min       <= n_x_min;
      x_max       <= c_x_max;
      y_min       <= n_y_min;
      y_max       <= c_y_max;
      x_cur       <= n_x_min;
      y_cur       <= n_y_min;
      fill_colour <= colour;
    end else if (accept && !last_pixel) begin
      if (x_cur == x_max) begin
        x_cur <= x_min;
        y_cur <= y_cur + 9'd1;
      end else begin
        x_cur <= x_cur + 9'd1;
      end
    end
  end

endmodule
